// File: rtl/ce_slot_scheduler_pkg.sv
// ce_slot_scheduler_pkg
//   Shared definitions for the clock-enable slot scheduler.
//   - CE_DIV_DEFAULT : divide ratio loaded at reset.
//   - ce_clog2()     : pointer width helper (never returns less than 1).
package ce_slot_scheduler_pkg;

    localparam int CE_DIV_DEFAULT = 7;

    function automatic int ce_clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >>> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/ce_slot_scheduler_rr_arbiter.sv
// rr_arbiter
//   Purely combinational round-robin arbiter.
//   Ports:
//     REQ     in  N_REQ  request vector
//     PTR     in  PTR_W  index with highest priority
//     EN_ARB  in  1      arbitration enable (grant only when high)
//     GNT     out N_REQ  one-hot grant, zero when disabled or no request
//     GNT_IDX out PTR_W  index of the granted requester
//     ANY     out 1      a grant is being issued
module rr_arbiter
    import ce_slot_scheduler_pkg::*;
#(
    parameter int N_REQ = 4,
    localparam int PTR_W = ce_clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] REQ,
    input  logic [PTR_W-1:0] PTR,
    input  logic             EN_ARB,
    output logic [N_REQ-1:0] GNT,
    output logic [PTR_W-1:0] GNT_IDX,
    output logic             ANY
);

    // One extra bit so PTR + offset can exceed N_REQ before the modulo fold.
    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;

    always_comb begin
        GNT     = '0;
        GNT_IDX = '0;
        ANY     = 1'b0;
        sum     = '0;
        idx     = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            sum = {1'b0, PTR} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(N_REQ)) begin
                sum = sum - (PTR_W+1)'(N_REQ);
            end
            idx = PTR_W'(sum);
            if (EN_ARB && !ANY && REQ[idx]) begin
                GNT[idx] = 1'b1;
                GNT_IDX  = idx;
                ANY      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ce_slot_scheduler.sv
// ce_slot_scheduler
//   Programmable clock-enable generator with round-robin slot grants.
//   Ports:
//     CLK        in  1      system clock
//     RST        in  1      synchronous active-high reset
//     EN         in  1      run enable; low freezes counter, no ticks
//     CFG_DIV    in  DIV_W  requested divide ratio (0 treated as 1)
//     CFG_VALID  in  1      config request valid
//     CFG_READY  out 1      pending config slot free
//     REQ        in  N_REQ  per-requester level request
//     GNT        out N_REQ  one-hot grant, coincident with CEO
//     CEO        out 1      single-cycle tick
//     IDLE_TICK  out 1      tick with no request present
//     STATE      out DIV_W  current counter value
//     PTR        out PTR_W  round-robin priority pointer
module ce_slot_scheduler
    import ce_slot_scheduler_pkg::*;
#(
    parameter int N_REQ       = 4,
    parameter int DIV_W       = 8,
    parameter int DIV_DEFAULT = CE_DIV_DEFAULT,
    localparam int PTR_W      = ce_clog2(N_REQ)
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             EN,
    input  logic [DIV_W-1:0] CFG_DIV,
    input  logic             CFG_VALID,
    output logic             CFG_READY,
    input  logic [N_REQ-1:0] REQ,
    output logic [N_REQ-1:0] GNT,
    output logic             CEO,
    output logic             IDLE_TICK,
    output logic [DIV_W-1:0] STATE,
    output logic [PTR_W-1:0] PTR
);

    localparam logic [DIV_W-1:0] DIV_INIT =
        (DIV_DEFAULT < 1) ? DIV_W'(1) : DIV_W'(DIV_DEFAULT);

    logic [DIV_W-1:0] state_q;
    logic [DIV_W-1:0] div_q;
    logic [DIV_W-1:0] pend_div_q;
    logic             pend_valid_q;
    logic [PTR_W-1:0] ptr_q;

    logic             ceo;
    logic             any;
    logic [PTR_W-1:0] gnt_idx;
    logic [N_REQ-1:0] gnt;
    logic [PTR_W-1:0] ptr_next;

    // div_q is never 0 (all writes force >= 1), so div_q-1 cannot underflow.
    assign ceo = EN && !RST && (state_q == div_q - DIV_W'(1));

    rr_arbiter #(
        .N_REQ (N_REQ)
    ) u_arb (
        .REQ     (REQ),
        .PTR     (ptr_q),
        .EN_ARB  (ceo),
        .GNT     (gnt),
        .GNT_IDX (gnt_idx),
        .ANY     (any)
    );

    assign ptr_next = (gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q      <= '0;
            div_q        <= DIV_INIT;
            pend_div_q   <= DIV_INIT;
            pend_valid_q <= 1'b0;
            ptr_q        <= '0;
        end else begin
            if (EN) begin
                if (ceo) begin
                    state_q <= '0;
                    // New ratio only takes effect on a period boundary.
                    if (pend_valid_q) begin
                        div_q        <= pend_div_q;
                        pend_valid_q <= 1'b0;
                    end
                    if (any) begin
                        ptr_q <= ptr_next;
                    end
                end else begin
                    state_q <= state_q + DIV_W'(1);
                end
            end
            // Accept only into an empty slot, so this never collides with
            // the apply-and-clear above.
            if (CFG_VALID && !pend_valid_q) begin
                pend_div_q   <= (CFG_DIV == '0) ? DIV_W'(1) : CFG_DIV;
                pend_valid_q <= 1'b1;
            end
        end
    end

    assign CFG_READY = !pend_valid_q;
    assign GNT       = gnt;
    assign CEO       = ceo;
    assign IDLE_TICK = ceo && (REQ == '0);
    assign STATE     = state_q;
    assign PTR       = ptr_q;

endmodule

// File: tb/tb_ce_slot_scheduler.sv
// tb_ce_slot_scheduler
//   Self-checking bench: directed scenarios plus random traffic, compared
//   against a period/queue-level reference model of the scheduler.
module tb_ce_slot_scheduler;

    localparam int N       = 4;
    localparam int DIV_W   = 8;
    localparam int PTR_W   = 2;
    localparam int DIV_DEF = 7;

    logic             clk = 1'b0;
    logic             rst, en, cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic [N-1:0]     req;
    logic             cfg_ready, ceo, idle_tick;
    logic [N-1:0]     gnt;
    logic [DIV_W-1:0] state;
    logic [PTR_W-1:0] ptr;

    ce_slot_scheduler #(
        .N_REQ       (N),
        .DIV_W       (DIV_W),
        .DIV_DEFAULT (DIV_DEF)
    ) dut (
        .CLK       (clk),
        .RST       (rst),
        .EN        (en),
        .CFG_DIV   (cfg_div),
        .CFG_VALID (cfg_valid),
        .CFG_READY (cfg_ready),
        .REQ       (req),
        .GNT       (gnt),
        .CEO       (ceo),
        .IDLE_TICK (idle_tick),
        .STATE     (state),
        .PTR       (ptr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Reference model: position within the period, active ratio, queued
    // ratio requests, and the requester that has priority next.
    int m_cnt  = 0;
    int m_div  = DIV_DEF;
    int m_ptr  = 0;
    int m_pend[$];

    logic         e_ceo, e_idle, e_rdy;
    logic [N-1:0] e_gnt;

    function automatic int grant_index(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (((r >> i) & 4'd1) != 4'd0) return i;
        end
        return -1;
    endfunction

    task automatic expect_now();
        int g;
        e_ceo  = en && !rst && (m_cnt == m_div - 1);
        g      = grant_index(req, m_ptr);
        e_gnt  = (e_ceo && g >= 0) ? 4'(1 << g) : 4'b0;
        e_idle = e_ceo && (req == 4'b0);
        e_rdy  = (m_pend.size() == 0);
    endtask

    task automatic model_update();
        bit ready_before, tk;
        int g;
        if (rst) begin
            m_cnt = 0; m_div = DIV_DEF; m_ptr = 0; m_pend.delete();
        end else begin
            ready_before = (m_pend.size() == 0);
            tk = en && (m_cnt == m_div - 1);
            if (en) begin
                if (tk) begin
                    g = grant_index(req, m_ptr);
                    if (g >= 0) m_ptr = (g + 1) % N;
                    m_cnt = 0;
                    if (m_pend.size() > 0) m_div = m_pend.pop_front();
                end else begin
                    m_cnt = m_cnt + 1;
                end
            end
            if (cfg_valid && ready_before)
                m_pend.push_back((cfg_div == 0) ? 1 : int'(cfg_div));
        end
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; req = 4'b1111; cfg_valid = 1'b0; cfg_div = '0;
        edge_step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_chk++;
            if ({ceo, gnt, idle_tick} !== 6'b0) begin
                n_fail++;
                $display("FAIL reset_outputs cyc=%0d got ceo/gnt/idle=%b/%b/%b exp 0/0000/0", cyc, ceo, gnt, idle_tick);
            end
            n_chk++;
            if ({state, ptr, cfg_ready} !== {8'd0, 2'd0, 1'b1}) begin
                n_fail++;
                $display("FAIL reset_state cyc=%0d got state=%0d ptr=%0d rdy=%b exp 0/0/1", cyc, state, ptr, cfg_ready);
            end
            if (i < 4) edge_step();
        end
        edge_step();
        rst = 1'b0; req = 4'b0;
    endtask

    task automatic test_period();
        int ticks, first;
        ticks = 0; first = -1;
        for (int i = 1; i <= 21; i++) begin
            @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, gnt, idle_tick, cfg_ready} !== {e_ceo, e_gnt, e_idle, e_rdy}) begin
                n_fail++;
                $display("FAIL period_out cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, ceo, gnt, idle_tick, cfg_ready, e_ceo, e_gnt, e_idle, e_rdy);
            end
            n_chk++;
            if ({state, ptr} !== {8'(m_cnt), 2'(m_ptr)}) begin
                n_fail++;
                $display("FAIL period_state cyc=%0d got state=%0d ptr=%0d exp %0d/%0d", cyc, state, ptr, m_cnt, m_ptr);
            end
            if (ceo === 1'b1) begin
                ticks++;
                if (first < 0) first = i;
            end
            edge_step();
        end
        n_chk++;
        if (first != 7 || ticks != 3) begin
            n_fail++;
            $display("FAIL period_count got first=%0d ticks=%0d exp first=7 ticks=3", first, ticks);
        end
    endtask

    task automatic test_cfg_midcount();
        for (int i = 0; i < 20 && m_cnt != 2; i++) edge_step();
        cfg_valid = 1'b1; cfg_div = 8'd3;
        edge_step();
        cfg_valid = 1'b0; cfg_div = 8'd0;
        @(negedge clk);
        n_chk++;
        if (cfg_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL cfg_ready_drop got %b exp 0", cfg_ready);
        end
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, gnt, idle_tick, cfg_ready} !== {e_ceo, e_gnt, e_idle, e_rdy}) begin
                n_fail++;
                $display("FAIL cfg_mid_out cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, ceo, gnt, idle_tick, cfg_ready, e_ceo, e_gnt, e_idle, e_rdy);
            end
            n_chk++;
            if (state !== 8'(m_cnt)) begin
                n_fail++;
                $display("FAIL cfg_mid_state cyc=%0d got %0d exp %0d", cyc, state, m_cnt);
            end
            edge_step();
        end
    endtask

    task automatic test_cfg_on_tick();
        expect_now();
        for (int i = 0; i < 20 && !e_ceo; i++) begin
            edge_step();
            expect_now();
        end
        cfg_valid = 1'b1; cfg_div = 8'd4;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, cfg_ready, state} !== {e_ceo, e_rdy, 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL cfg_tick cyc=%0d got ceo=%b rdy=%b state=%0d exp %b/%b/%0d", cyc, ceo, cfg_ready, state, e_ceo, e_rdy, m_cnt);
            end
            edge_step();
            cfg_valid = 1'b0;
        end
    endtask

    task automatic test_rr_all();
        logic [N-1:0] gseq [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        int           pseq [5] = '{1, 2, 3, 0, 1};
        int tk;
        tk = 0;
        req = 4'b1111;
        for (int i = 0; i < 40 && tk < 5; i++) begin
            @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, gnt, idle_tick} !== {e_ceo, e_gnt, e_idle}) begin
                n_fail++;
                $display("FAIL rr_all_out cyc=%0d got %b/%b/%b exp %b/%b/%b", cyc, ceo, gnt, idle_tick, e_ceo, e_gnt, e_idle);
            end
            if (e_ceo) begin
                n_chk++;
                if (gnt !== gseq[tk]) begin
                    n_fail++;
                    $display("FAIL rr_all_gnt tick=%0d got %b exp %b", tk, gnt, gseq[tk]);
                end
                edge_step();
                n_chk++;
                if (ptr !== 2'(pseq[tk])) begin
                    n_fail++;
                    $display("FAIL rr_all_ptr tick=%0d got %0d exp %0d", tk, ptr, pseq[tk]);
                end
                tk++;
            end else begin
                edge_step();
            end
        end
        n_chk++;
        if (tk != 5) begin
            n_fail++;
            $display("FAIL rr_all_timeout got ticks=%0d exp 5", tk);
        end
    endtask

    task automatic test_rr_pattern();
        logic [N-1:0] rseq [3] = '{4'b0010, 4'b1010, 4'b1010};
        logic [N-1:0] gseq [3] = '{4'b0010, 4'b1000, 4'b0010};
        int           pseq [3] = '{2, 0, 2};
        for (int s = 0; s < 3; s++) begin
            bit done;
            done = 1'b0;
            req = rseq[s];
            for (int i = 0; i < 20 && !done; i++) begin
                @(negedge clk);
                expect_now();
                n_chk++;
                if ({ceo, gnt} !== {e_ceo, e_gnt}) begin
                    n_fail++;
                    $display("FAIL rr_pat_out cyc=%0d got %b/%b exp %b/%b", cyc, ceo, gnt, e_ceo, e_gnt);
                end
                if (e_ceo) begin
                    n_chk++;
                    if (gnt !== gseq[s]) begin
                        n_fail++;
                        $display("FAIL rr_pat_gnt stage=%0d got %b exp %b", s, gnt, gseq[s]);
                    end
                    edge_step();
                    n_chk++;
                    if (ptr !== 2'(pseq[s])) begin
                        n_fail++;
                        $display("FAIL rr_pat_ptr stage=%0d got %0d exp %0d", s, ptr, pseq[s]);
                    end
                    done = 1'b1;
                end else begin
                    edge_step();
                end
            end
            n_chk++;
            if (!done) begin
                n_fail++;
                $display("FAIL rr_pat_timeout stage=%0d got no tick exp tick", s);
            end
        end
        req = 4'b0;
    endtask

    task automatic test_reset_mid();
        int ticks;
        ticks = 0;
        for (int i = 0; i < 20 && m_cnt != 1; i++) edge_step();
        cfg_valid = 1'b1; cfg_div = 8'd2;
        edge_step();
        cfg_valid = 1'b0;
        for (int i = 0; i < 20 && m_cnt != 3; i++) edge_step();
        req = 4'b0101;
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({ceo, gnt, idle_tick} !== 6'b0) begin
            n_fail++;
            $display("FAIL rstmid_suppress got ceo/gnt/idle=%b/%b/%b exp 0/0000/0", ceo, gnt, idle_tick);
        end
        edge_step();
        rst = 1'b0; req = 4'b0;
        @(negedge clk);
        n_chk++;
        if ({state, cfg_ready, ptr} !== {8'd0, 1'b1, 2'd0}) begin
            n_fail++;
            $display("FAIL rstmid_state got state=%0d rdy=%b ptr=%0d exp 0/1/0", state, cfg_ready, ptr);
        end
        for (int i = 0; i < 14; i++) begin
            if (i > 0) @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, state} !== {e_ceo, 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL rstmid_run cyc=%0d got ceo=%b state=%0d exp %b/%0d", cyc, ceo, state, e_ceo, m_cnt);
            end
            if (ceo === 1'b1) ticks++;
            edge_step();
        end
        n_chk++;
        if (ticks != 2) begin
            n_fail++;
            $display("FAIL rstmid_period got ticks=%0d exp 2", ticks);
        end
    endtask

    task automatic test_en_freeze();
        logic [DIV_W-1:0] held;
        repeat (3) edge_step();
        en = 1'b0;
        held = 8'(m_cnt);
        for (int i = 0; i < 10; i++) begin
            cfg_valid = (i == 2); cfg_div = 8'd2;
            @(negedge clk);
            n_chk++;
            if ({ceo, gnt, state} !== {1'b0, 4'b0, held}) begin
                n_fail++;
                $display("FAIL freeze cyc=%0d got ceo=%b gnt=%b state=%0d exp 0/0000/%0d", cyc, ceo, gnt, state, held);
            end
            edge_step();
        end
        cfg_valid = 1'b0;
        en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, cfg_ready, state} !== {e_ceo, e_rdy, 8'(m_cnt)}) begin
                n_fail++;
                $display("FAIL thaw cyc=%0d got ceo=%b rdy=%b state=%0d exp %b/%b/%0d", cyc, ceo, cfg_ready, state, e_ceo, e_rdy, m_cnt);
            end
            edge_step();
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rst       = ($urandom_range(0, 199) == 0);
            en        = ($urandom_range(0, 7) != 0);
            req       = 4'($urandom);
            cfg_valid = ($urandom_range(0, 5) == 0);
            cfg_div   = 8'($urandom_range(0, 5));
            @(negedge clk);
            expect_now();
            n_chk++;
            if ({ceo, gnt, idle_tick, cfg_ready} !== {e_ceo, e_gnt, e_idle, e_rdy}) begin
                n_fail++;
                $display("FAIL rand_out cyc=%0d got %b/%b/%b/%b exp %b/%b/%b/%b", cyc, ceo, gnt, idle_tick, cfg_ready, e_ceo, e_gnt, e_idle, e_rdy);
            end
            n_chk++;
            if ({state, ptr} !== {8'(m_cnt), 2'(m_ptr)}) begin
                n_fail++;
                $display("FAIL rand_state cyc=%0d got state=%0d ptr=%0d exp %0d/%0d", cyc, state, ptr, m_cnt, m_ptr);
            end
            edge_step();
        end
        rst = 1'b0; en = 1'b1; cfg_valid = 1'b0; req = 4'b0;
    endtask

    initial begin
        test_reset();
        test_period();
        test_cfg_midcount();
        test_cfg_on_tick();
        test_rr_all();
        test_rr_pattern();
        test_reset_mid();
        test_en_freeze();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/ce_slot_scheduler.md
Name: ce_slot_scheduler

Overview:
- Programmable clock-enable generator and time-slot scheduler.
- Produces a periodic single-cycle tick (CEO) from CLK with a divide ratio that can be reconfigured at runtime without glitches.
- On each tick, grants that slot to one of N_REQ requesters in round-robin order.
- Sits between the clock-enable source and slow peripherals that share one enable-rate resource.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DIV_W, 8, width of divide-ratio and counter.
- DIV_DEFAULT, 7, divide ratio loaded at reset (1..2^DIV_W-1).
- PTR_W, clog2(N_REQ), round-robin pointer width (derived, not overridden).

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  run enable; low freezes counter and suppresses ticks/grants.
- CFG_DIV  in  DIV_W  requested divide ratio.
- CFG_VALID  in  1  config request valid.
- CFG_READY  out  1  config slot free.
- REQ  in  N_REQ  per-requester slot request (level).
- GNT  out  N_REQ  one-hot slot grant, pulse coincident with CEO.
- CEO  out  1  tick pulse, one CLK cycle wide.
- IDLE_TICK  out  1  tick with REQ==0.
- STATE  out  DIV_W  current counter value.
- PTR  out  PTR_W  current round-robin priority pointer.

Behaviour:
- Reset, synchronous and active-high: STATE=0, div_reg=DIV_DEFAULT, pending empty, CFG_READY=1, PTR=0, CEO=GNT=IDLE_TICK=0 during reset.
- Counter:
  - While EN=1, STATE counts 0..div_reg-1 and wraps to 0.
  - While EN=0, STATE holds.
  - A stored value of 0 is treated as 1.
- Tick:
  - CEO = EN && (STATE == div_reg-1), combinational from registers.
  - With div_reg=1, CEO=1 on every enabled cycle.
  - After reset release with EN=1 and default 7, the first CEO occurs when STATE=6, in the 7th cycle, then every 7 cycles.
- Config handshake:
  - Transfer happens on CFG_VALID && CFG_READY at the clock edge. CFG_DIV goes into a one-entry pending register and CFG_READY drops.
  - At the next tick edge (CEO=1), div_reg <= pending, STATE <= 0, pending clears, CFG_READY returns to 1.
  - If the transfer and a tick occur in the same cycle, the tick uses the old div_reg and the new value applies at the following tick.
  - The period is never truncated mid-count.
  - While EN=0, pending waits indefinitely.
  - CFG_DIV=0 is stored as 1.
- Grant:
  - In a CEO cycle, GNT is one-hot for the first set REQ bit searching from index PTR upward, with modulo N_REQ wrap.
  - If REQ==0, GNT=0 and IDLE_TICK=1.
  - Outside CEO cycles, GNT=0 and IDLE_TICK=0.
  - On the edge after a grant to index i, PTR <= (i+1) mod N_REQ.
  - PTR is unchanged on idle ticks.
- REQ is sampled only in the CEO cycle. Deassertion between ticks has no effect.
- RST mid-period discards pending config, restores DIV_DEFAULT and PTR=0, and suppresses that cycle's outputs.
- No combinational path from CFG_* to CEO/GNT. REQ->GNT is combinational and gated by CEO.

Decomposition:
- Shared header (ce_sched_defs): DIV_DEFAULT and the clog2 helper function.
- One natural sub-module, rr_arbiter:
  - parameter N_REQ;
  - inputs REQ, PTR, EN_ARB (=CEO);
  - outputs GNT, GNT_IDX, ANY.
  - Purely combinational.
- Counter, config pending register and PTR update live in the top.

Test Plan:
1. Reset 5 cycles then EN=1, REQ=0 -> CEO at STATE=6, period 7 cycles; IDLE_TICK=1 with each CEO; GNT=0; PTR stays 0.
2. CFG_DIV=3 pulsed with STATE=2 -> CFG_READY=0 until the next tick; the current 7-cycle period completes, then the period is 3 (CEO at STATE=2); CFG_READY=1 after the tick edge.
3. CFG_VALID coincident with a CEO cycle, CFG_DIV=4 -> the next period is still the old ratio; the 4-cycle period starts after the following tick.
4. REQ=4'b1111 held -> successive ticks grant 0001, 0010, 0100, 1000, 0001; PTR sequence 1, 2, 3, 0.
5. REQ=4'b1010, PTR=2 at tick -> GNT=1000, PTR becomes 0. At the next tick GNT=0010.
6. RST asserted at STATE=3 with pending CFG_DIV=2 -> after release, STATE=0, period 7, CFG_READY=1, PTR=0. EN=0 for 10 cycles freezes STATE with no CEO.
